// File: rtl/tx_frontend_gen3_pkg.sv
// tx_frontend_gen3_pkg
//   Shared definitions for the transmit front end: default settings-bus
//   addresses, IQ mapping control bit positions, the up-converter phase
//   type and the 16-bit saturation helpers used by every datapath stage.
//   Optional feature macro used by the top: TX_FRONTEND_GEN3_SAT_CNT_EN.
package tx_frontend_gen3_pkg;

    localparam logic [7:0] DEF_SR_MAG_CORRECTION   = 8'd0;
    localparam logic [7:0] DEF_SR_PHASE_CORRECTION = 8'd1;
    localparam logic [7:0] DEF_SR_OFFSET_I         = 8'd2;
    localparam logic [7:0] DEF_SR_OFFSET_Q         = 8'd3;
    localparam logic [7:0] DEF_SR_IQ_MAPPING       = 8'd4;
    localparam logic [7:0] DEF_SR_HET_PHASE_INCR   = 8'd5;

    localparam int MAP_SWAP_IQ    = 0;
    localparam int MAP_INVERT_Q   = 2;
    localparam int MAP_INVERT_I   = 3;
    localparam int MAP_UPCONVERT  = 4;
    localparam int MAP_BYPASS_ALL = 7;

    typedef logic [1:0] phase_t;

    function automatic logic signed [15:0] sat16(input logic signed [17:0] x);
        if (x > 18'sd32767)
            return 16'sh7FFF;
        else if (x < -18'sd32768)
            return 16'sh8000;
        else
            return x[15:0];
    endfunction

    function automatic logic is_sat16(input logic signed [17:0] x);
        return (x > 18'sd32767) || (x < -18'sd32768);
    endfunction

    // Negation that maps -32768 to +32767 instead of wrapping.
    function automatic logic signed [15:0] neg16(input logic signed [15:0] x);
        return sat16(-18'(x));
    endfunction

endpackage

// File: rtl/tx_fs4_upconv.sv
// tx_fs4_upconv
//   fs/4 heterodyne up-converter: rotates each strobed sample by a multiple
//   of pi/2 chosen by a 2-bit phase counter, with a 1-cycle registered output.
// Ports:
//   clk, reset_n        clock, async active-low reset
//   stb_in, i_in, q_in  input sample and its valid strobe
//   sync                forces the current (or next) sample to phase 0
//   enable              1 = rotate, 0 = pass-through (counter still runs)
//   direction           0 = +pi/2 per sample, 1 = -pi/2 per sample
//   stb_out, i_out, q_out  registered output sample
module tx_fs4_upconv
    import tx_frontend_gen3_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stb_in,
    input  logic               sync,
    input  logic               enable,
    input  logic               direction,
    input  logic signed [15:0] i_in,
    input  logic signed [15:0] q_in,
    output logic               stb_out,
    output logic signed [15:0] i_out,
    output logic signed [15:0] q_out
);

    phase_t             phase;
    phase_t             phase_use;
    logic signed [15:0] rot_i;
    logic signed [15:0] rot_q;

    // phase holds the phase of the next strobed sample; sync overrides it.
    always_comb begin
        phase_use = sync ? 2'd0 : phase;
        rot_i     = i_in;
        rot_q     = q_in;
        if (enable) begin
            case (phase_use)
                2'd0: begin rot_i = i_in;         rot_q = q_in;         end
                2'd1: begin rot_i = neg16(q_in);  rot_q = i_in;         end
                2'd2: begin rot_i = neg16(i_in);  rot_q = neg16(q_in);  end
                default: begin rot_i = q_in;      rot_q = neg16(i_in);  end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase   <= 2'd0;
            stb_out <= 1'b0;
            i_out   <= '0;
            q_out   <= '0;
        end else begin
            stb_out <= stb_in;
            if (stb_in) begin
                phase <= direction ? phase_use - 2'd1 : phase_use + 2'd1;
                i_out <= rot_i;
                q_out <= rot_q;
            end else if (sync) begin
                phase <= 2'd0;
            end
        end
    end

endmodule

// File: rtl/tx_frontend_gen3.sv
// tx_frontend_gen3
//   TX front end: IQ mapping -> fs/4 up-conversion -> IQ imbalance
//   pre-correction -> DC offset, fixed 4-cycle latency, no backpressure.
//   Optional macro TX_FRONTEND_GEN3_SAT_CNT_EN enables the saturation counter;
//   without it sat_count is tied to 0.
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   sync_in                       resets up-converter phase to 0
//   set_stb, set_addr, set_data   settings bus write
//   tx_stb, tx_i, tx_q            baseband input sample
//   dac_stb, dac_i, dac_q         DAC output sample
//   sat_count                     saturated output sample count
module tx_frontend_gen3
    import tx_frontend_gen3_pkg::*;
#(
    parameter logic [7:0] SR_MAG_CORRECTION   = DEF_SR_MAG_CORRECTION,
    parameter logic [7:0] SR_PHASE_CORRECTION = DEF_SR_PHASE_CORRECTION,
    parameter logic [7:0] SR_OFFSET_I         = DEF_SR_OFFSET_I,
    parameter logic [7:0] SR_OFFSET_Q         = DEF_SR_OFFSET_Q,
    parameter logic [7:0] SR_IQ_MAPPING       = DEF_SR_IQ_MAPPING,
    parameter logic [7:0] SR_HET_PHASE_INCR   = DEF_SR_HET_PHASE_INCR
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sync_in,
    input  logic               set_stb,
    input  logic [7:0]         set_addr,
    input  logic [31:0]        set_data,
    input  logic               tx_stb,
    input  logic signed [15:0] tx_i,
    input  logic signed [15:0] tx_q,
    output logic               dac_stb,
    output logic signed [15:0] dac_i,
    output logic signed [15:0] dac_q,
    output logic [15:0]        sat_count
);

    logic signed [17:0] mag_corr, phase_corr;
    logic signed [15:0] offset_i, offset_q;
    logic [7:0]         iq_map;
    logic               het_dir;
    logic               map_wr;

    assign map_wr = set_stb && (set_addr == SR_IQ_MAPPING);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mag_corr   <= '0;
            phase_corr <= '0;
            offset_i   <= '0;
            offset_q   <= '0;
            iq_map     <= '0;
            het_dir    <= 1'b0;
        end else if (set_stb) begin
            if (set_addr == SR_MAG_CORRECTION)   mag_corr   <= set_data[17:0];
            if (set_addr == SR_PHASE_CORRECTION) phase_corr <= set_data[17:0];
            if (set_addr == SR_OFFSET_I)         offset_i   <= set_data[15:0];
            if (set_addr == SR_OFFSET_Q)         offset_q   <= set_data[15:0];
            if (set_addr == SR_IQ_MAPPING)       iq_map     <= set_data[7:0];
            if (set_addr == SR_HET_PHASE_INCR)   het_dir    <= set_data[0];
        end
    end

    // Stage 1: swap, then saturating inversion. Bypass state travels with
    // each sample so later stages treat it consistently.
    logic signed [15:0] swp_i, swp_q, map_i, map_q;
    logic               map_sat;

    always_comb begin
        swp_i   = iq_map[MAP_SWAP_IQ] ? tx_q : tx_i;
        swp_q   = iq_map[MAP_SWAP_IQ] ? tx_i : tx_q;
        map_i   = iq_map[MAP_INVERT_I] ? neg16(swp_i) : swp_i;
        map_q   = iq_map[MAP_INVERT_Q] ? neg16(swp_q) : swp_q;
        map_sat = (iq_map[MAP_INVERT_I] && (swp_i == 16'sh8000)) ||
                  (iq_map[MAP_INVERT_Q] && (swp_q == 16'sh8000));
        if (iq_map[MAP_BYPASS_ALL]) begin
            map_i   = tx_i;
            map_q   = tx_q;
            map_sat = 1'b0;
        end
    end

    logic               s1_stb, s1_sync, s1_byp, s1_sat;
    logic signed [15:0] s1_i, s1_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_stb  <= 1'b0;
            s1_sync <= 1'b0;
            s1_byp  <= 1'b0;
            s1_sat  <= 1'b0;
            s1_i    <= '0;
            s1_q    <= '0;
        end else begin
            s1_stb  <= tx_stb;
            s1_sync <= sync_in;
            if (tx_stb) begin
                s1_i   <= map_i;
                s1_q   <= map_q;
                s1_byp <= iq_map[MAP_BYPASS_ALL];
                s1_sat <= map_sat;
            end
        end
    end

    // Stage 2: up-converter; sync_in is delayed one cycle to stay aligned
    // with the sample it arrived with.
    logic               s2_stb, s2_byp, s2_sat;
    logic signed [15:0] s2_i, s2_q;

    tx_fs4_upconv u_upconv (
        .clk       (clk),
        .reset_n   (reset_n),
        .stb_in    (s1_stb),
        .sync      (s1_sync),
        .enable    (iq_map[MAP_UPCONVERT] && !s1_byp),
        .direction (het_dir),
        .i_in      (s1_i),
        .q_in      (s1_q),
        .stb_out   (s2_stb),
        .i_out     (s2_i),
        .q_out     (s2_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_byp <= 1'b0;
            s2_sat <= 1'b0;
        end else if (s1_stb) begin
            s2_byp <= s1_byp;
            s2_sat <= s1_sat;
        end
    end

    // Stage 3: IQ imbalance; both corrections scale the I input.
    logic signed [33:0] prod_i, prod_q;
    logic signed [17:0] sum3_i, sum3_q;

    assign prod_i = 34'(mag_corr) * 34'(s2_i);
    assign prod_q = 34'(phase_corr) * 34'(s2_i);
    assign sum3_i = 18'(s2_i) + 18'(prod_i >>> 17);
    assign sum3_q = 18'(s2_q) + 18'(prod_q >>> 17);

    logic               s3_stb, s3_byp, s3_sat;
    logic signed [15:0] s3_i, s3_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s3_stb <= 1'b0;
            s3_byp <= 1'b0;
            s3_sat <= 1'b0;
            s3_i   <= '0;
            s3_q   <= '0;
        end else begin
            s3_stb <= s2_stb;
            if (s2_stb) begin
                s3_byp <= s2_byp;
                s3_i   <= s2_byp ? s2_i : sat16(sum3_i);
                s3_q   <= s2_byp ? s2_q : sat16(sum3_q);
                s3_sat <= s2_sat ||
                          (!s2_byp && (is_sat16(sum3_i) || is_sat16(sum3_q)));
            end
        end
    end

    // Stage 4: DC offset with a 17-bit intermediate.
    logic signed [16:0] sum4_i, sum4_q;
    logic               sat4;

    assign sum4_i = 17'(s3_i) + 17'(offset_i);
    assign sum4_q = 17'(s3_q) + 17'(offset_q);
    assign sat4   = !s3_byp && (is_sat16(18'(sum4_i)) || is_sat16(18'(sum4_q)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dac_stb <= 1'b0;
            dac_i   <= '0;
            dac_q   <= '0;
        end else begin
            dac_stb <= s3_stb;
            if (s3_stb) begin
                dac_i <= s3_byp ? s3_i : sat16(18'(sum4_i));
                dac_q <= s3_byp ? s3_q : sat16(18'(sum4_q));
            end
        end
    end

`ifdef TX_FRONTEND_GEN3_SAT_CNT_EN
    // Counts output samples that saturated anywhere; a mapping write clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            sat_count <= '0;
        else if (map_wr)
            sat_count <= '0;
        else if (s3_stb && (s3_sat || sat4) && (sat_count != 16'hFFFF))
            sat_count <= sat_count + 16'd1;
    end

    logic [16:0] bits_unused;
    assign bits_unused = {set_data[31:18], iq_map[6:5], iq_map[1]};
`else
    assign sat_count = '0;

    logic [19:0] bits_unused;
    assign bits_unused = {set_data[31:18], iq_map[6:5], iq_map[1],
                          map_wr, s3_sat, sat4};
`endif

endmodule

// File: tb/tb_tx_frontend_gen3.sv
// tb_tx_frontend_gen3
//   Self-checking bench for tx_frontend_gen3: directed vector table, hand
//   written up-conversion / sync / bypass sequences, a mid-stream reset and
//   randomized streams checked against a complex-arithmetic reference model.
//   Honours TX_FRONTEND_GEN3_SAT_CNT_EN for the expected sat_count.
module tb_tx_frontend_gen3;

`ifdef TX_FRONTEND_GEN3_SAT_CNT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset_n;
    logic               sync_in;
    logic               set_stb;
    logic [7:0]         set_addr;
    logic [31:0]        set_data;
    logic               tx_stb;
    logic signed [15:0] tx_i, tx_q;
    logic               dac_stb;
    logic signed [15:0] dac_i, dac_q;
    logic [15:0]        sat_count;

    tx_frontend_gen3 dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sync_in   (sync_in),
        .set_stb   (set_stb),
        .set_addr  (set_addr),
        .set_data  (set_data),
        .tx_stb    (tx_stb),
        .tx_i      (tx_i),
        .tx_q      (tx_q),
        .dac_stb   (dac_stb),
        .dac_i     (dac_i),
        .dac_q     (dac_q),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;

    int asserts = 0;
    int fails   = 0;

    // Reference model state: configuration, phase of next sample,
    // expected outputs in flight and the last value seen on the DAC.
    typedef struct { int i; int q; bit sat; } exp_t;
    exp_t exp_q[$];
    bit   stb_pipe[$];
    int   m_mag, m_phase, m_offi, m_offq, m_ph, m_cnt, last_i, last_q;
    bit   m_dir;
    logic [7:0] m_map;
    int   cos_t[4] = '{1, 0, -1, 0};
    int   sin_t[4] = '{0, 1, 0, -1};

    typedef struct {
        logic [7:0]  map;
        logic [17:0] mag;
        logic [17:0] ph;
        logic [15:0] offi;
        logic [15:0] offq;
        int in_i; int in_q; int exp_i; int exp_q; bit exp_sat;
    } vec_t;
    vec_t vecs[12];

    task automatic check_output(input string name, input int act, input int expv);
        asserts++;
        if (act != expv) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    function automatic int clamp(input int x);
        return (x > 32767) ? 32767 : (x < -32768) ? -32768 : x;
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        stb_pipe.delete();
        repeat (3) stb_pipe.push_back(1'b0);
        m_mag = 0; m_phase = 0; m_offi = 0; m_offq = 0; m_map = '0; m_dir = 0;
        m_ph = 0; m_cnt = 0; last_i = 0; last_q = 0;
    endfunction

    // Sample = complex number; up-conversion multiplies it by j^phase.
    function automatic void model_sample(input int i, input int q, input bit sync);
        int   use_ph, a, b, t;
        bit   sat;
        exp_t e;
        if (sync) m_ph = 0;
        use_ph = m_ph;
        m_ph   = (m_ph + (m_dir ? 3 : 1)) % 4;
        a = i; b = q; sat = 0;
        if (!m_map[7]) begin
            if (m_map[0]) begin t = a; a = b; b = t; end
            if (m_map[3]) begin if (a == -32768) sat = 1; a = clamp(-a); end
            if (m_map[2]) begin if (b == -32768) sat = 1; b = clamp(-b); end
            if (m_map[4]) begin
                t = clamp(cos_t[use_ph] * a - sin_t[use_ph] * b);
                b = clamp(sin_t[use_ph] * a + cos_t[use_ph] * b);
                a = t;
            end
            t = a + int'((longint'(m_mag) * a) >>> 17);
            b = b + int'((longint'(m_phase) * a) >>> 17);
            a = t;
            if (a != clamp(a) || b != clamp(b)) sat = 1;
            a = clamp(a) + m_offi;
            b = clamp(b) + m_offq;
            if (a != clamp(a) || b != clamp(b)) sat = 1;
            a = clamp(a);
            b = clamp(b);
        end
        e.i = a; e.q = b; e.sat = sat;
        exp_q.push_back(e);
    endfunction

    function automatic void model_write(input logic [7:0] addr, input logic [31:0] data);
        case (addr)
            8'd0: m_mag   = int'($signed(data[17:0]));
            8'd1: m_phase = int'($signed(data[17:0]));
            8'd2: m_offi  = int'($signed(data[15:0]));
            8'd3: m_offq  = int'($signed(data[15:0]));
            8'd4: begin m_map = data[7:0]; m_cnt = 0; end
            8'd5: m_dir   = data[0];
            default: ;
        endcase
    endfunction

    // Compare everything the DUT shows after one clock against the model.
    task automatic check_cycle();
        bit   es;
        exp_t e;
        es = stb_pipe.pop_front();
        check_output("dac_stb", int'(dac_stb), int'(es));
        if (es) begin
            if (exp_q.size() == 0) begin
                check_output("exp_queue_empty", 1, 0);
            end else begin
                e = exp_q.pop_front();
                last_i = e.i;
                last_q = e.q;
                if (e.sat && m_cnt != 65535) m_cnt++;
            end
        end
        check_output("dac_i", int'(dac_i), last_i);
        check_output("dac_q", int'(dac_q), last_q);
        check_output("sat_count", int'(sat_count), SAT_EN ? m_cnt : 0);
    endtask

    task automatic apply_stimulus(input bit stb, input int i, input int q, input bit sync,
                                  input bit wr, input logic [7:0] addr, input logic [31:0] data);
        tx_stb = stb; tx_i = 16'(i); tx_q = 16'(q); sync_in = sync;
        set_stb = wr; set_addr = addr; set_data = data;
        if (stb) model_sample(i, q, sync);
        else if (sync) m_ph = 0;
        stb_pipe.push_back(stb);
        @(posedge clk);
        #1;
        if (wr) model_write(addr, data);
        check_cycle();
    endtask

    task automatic flush(input int n);
        repeat (n) apply_stimulus(0, 0, 0, 0, 0, 8'd0, 32'd0);
    endtask

    task automatic configure(input logic [7:0] map, input logic [17:0] mag, input logic [17:0] ph,
                             input logic [15:0] offi, input logic [15:0] offq, input bit dir);
        flush(4);
        apply_stimulus(0, 0, 0, 0, 1, 8'd0, {14'd0, mag});
        apply_stimulus(0, 0, 0, 0, 1, 8'd1, {14'd0, ph});
        apply_stimulus(0, 0, 0, 0, 1, 8'd2, {16'd0, offi});
        apply_stimulus(0, 0, 0, 0, 1, 8'd3, {16'd0, offq});
        apply_stimulus(0, 0, 0, 0, 1, 8'd5, {31'd0, dir});
        apply_stimulus(0, 0, 0, 0, 1, 8'd4, {24'd0, map});
    endtask

    // Constant (14336,0) input stream; sample k carries sync when k == sync_idx.
    task automatic run_const_seq(input string name, input int n, input int sync_idx,
                                 input int ei[8], input int eq[8]);
        for (int k = 0; k < n + 3; k++) begin
            apply_stimulus(k < n, 14336, 0, k == sync_idx, 0, 8'd0, 32'd0);
            if (k >= 3) begin
                check_output($sformatf("%s_i%0d", name, k - 3), int'(dac_i), ei[k - 3]);
                check_output($sformatf("%s_q%0d", name, k - 3), int'(dac_q), eq[k - 3]);
            end
        end
    endtask

    function automatic int rnd_sample();
        case ($urandom_range(0, 7))
            0: return -32768;
            1: return 32767;
            default: return int'($signed(16'($urandom)));
        endcase
    endfunction

    initial begin
        int ei[8];
        int eq[8];
        int bin[5];

        vecs[0]  = '{8'h09, 18'h00000, 18'h00000, 16'h0000, 16'h0000,   100, -32768,  32767,    100, 1'b1};
        vecs[1]  = '{8'h00, 18'h10000, 18'h00000, 16'h0000, 16'h0000,  1000,      0,   1500,      0, 1'b0};
        vecs[2]  = '{8'h00, 18'h00000, 18'h00000, 16'd1000, 16'h0000, 32000,      5,  32767,      5, 1'b1};
        vecs[3]  = '{8'h04, 18'h00000, 18'h00000, 16'h0000, 16'h0000,     5,     -7,      5,      7, 1'b0};
        vecs[4]  = '{8'h00, 18'h00000, 18'h10000, 16'h0000, 16'h0000,  2000,    100,   2000,   1100, 1'b0};
        vecs[5]  = '{8'h00, 18'h20000, 18'h00000, 16'h0000, 16'h0000, -1000,      3,      0,      3, 1'b0};
        vecs[6]  = '{8'h00, 18'h00001, 18'h00000, 16'h0000, 16'h0000,    -1,      0,     -2,      0, 1'b0};
        vecs[7]  = '{8'h00, 18'h00000, 18'h00000, 16'h0000, 16'hFF9C,     0, -32700,      0, -32768, 1'b1};
        vecs[8]  = '{8'h80, 18'h10000, 18'h00000, 16'd1000, 16'h0000, -32768,  1234, -32768,   1234, 1'b0};
        vecs[9]  = '{8'h01, 18'h00000, 18'h00000, 16'h0000, 16'h0000,     7,     -9,     -9,      7, 1'b0};
        vecs[10] = '{8'h00, 18'h1FFFF, 18'h00000, 16'h0000, 16'h0000, 30000,      0,  32767,      0, 1'b1};
        vecs[11] = '{8'h00, 18'h10000, 18'h00000, 16'hFC18, 16'h0000,  1000,      0,    500,      0, 1'b0};

        reset_n = 1'b0;
        tx_stb = 0; tx_i = 0; tx_q = 0; sync_in = 0; set_stb = 0; set_addr = 0; set_data = 0;
        model_reset();
        #1;
        check_output("reset_dac_stb", int'(dac_stb), 0);
        check_output("reset_dac_i", int'(dac_i), 0);
        check_output("reset_sat_count", int'(sat_count), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        $display("[TB] reset released");

        for (int k = 0; k < 12; k++) begin
            configure(vecs[k].map, vecs[k].mag, vecs[k].ph, vecs[k].offi, vecs[k].offq, 1'b0);
            apply_stimulus(1, vecs[k].in_i, vecs[k].in_q, 0, 0, 8'd0, 32'd0);
            flush(4);
            check_output($sformatf("vec%0d_i", k), int'(dac_i), vecs[k].exp_i);
            check_output($sformatf("vec%0d_q", k), int'(dac_q), vecs[k].exp_q);
            check_output($sformatf("vec%0d_sat", k), int'(sat_count), SAT_EN ? int'(vecs[k].exp_sat) : 0);
        end

        $display("[TB] up-conversion sequences");
        configure(8'h10, 18'd0, 18'd0, 16'd0, 16'd0, 1'b0);
        ei = '{14336, 0, -14336, 0, 14336, 0, -14336, 0};
        eq = '{0, 14336, 0, -14336, 0, 14336, 0, -14336};
        run_const_seq("up_dir0", 8, 0, ei, eq);
        configure(8'h10, 18'd0, 18'd0, 16'd0, 16'd0, 1'b1);
        ei = '{14336, 0, -14336, 0, 14336, 0, -14336, 0};
        eq = '{0, -14336, 0, 14336, 0, -14336, 0, 14336};
        run_const_seq("up_dir1", 8, 0, ei, eq);
        configure(8'h10, 18'd0, 18'd0, 16'd0, 16'd0, 1'b0);
        ei = '{14336, 0, -14336, 14336, 0, -14336, 0, 0};
        eq = '{0, 14336, 0, 0, 14336, 0, 0, 0};
        run_const_seq("sync_mid", 6, 3, ei, eq);

        $display("[TB] bypass with gaps");
        configure(8'h90, 18'h10000, 18'd0, 16'd500, 16'd0, 1'b0);
        for (int k = 0; k < 13; k++) begin
            if (k < 10 && k % 2 == 0) begin
                bin[k / 2] = rnd_sample();
                apply_stimulus(1, bin[k / 2], -bin[k / 2] / 2, k == 0, 0, 8'd0, 32'd0);
            end else begin
                apply_stimulus(0, 0, 0, 0, 0, 8'd0, 32'd0);
            end
            if (k >= 3 && (k - 3) % 2 == 0 && (k - 3) / 2 < 5) begin
                check_output($sformatf("bypass_i%0d", (k - 3) / 2), int'(dac_i), bin[(k - 3) / 2]);
                check_output("bypass_stb", int'(dac_stb), 1);
            end
        end
        configure(8'h10, 18'd0, 18'd0, 16'd0, 16'd0, 1'b0);
        apply_stimulus(1, 14336, 0, 0, 0, 8'd0, 32'd0);
        flush(4);
        check_output("after_bypass_i", int'(dac_i), 0);
        check_output("after_bypass_q", int'(dac_q), 14336);

        $display("[TB] mid-stream reset");
        for (int k = 0; k < 3; k++) apply_stimulus(1, 1000 + k, -k, 0, 0, 8'd0, 32'd0);
        reset_n = 1'b0;
        tx_stb  = 1'b0;
        #1;
        check_output("midreset_dac_stb", int'(dac_stb), 0);
        check_output("midreset_dac_i", int'(dac_i), 0);
        check_output("midreset_dac_q", int'(dac_q), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int k = 0; k < 6; k++) apply_stimulus(1, rnd_sample(), rnd_sample(), 0, 0, 8'd0, 32'd0);

        $display("[TB] randomized streams");
        for (int r = 0; r < 8; r++) begin
            configure((8'($urandom) & 8'h1D) | (($urandom_range(0, 3) == 0) ? 8'h80 : 8'h00),
                      18'($urandom), 18'($urandom), 16'($urandom), 16'($urandom),
                      1'($urandom_range(0, 1)));
            for (int k = 0; k < 40; k++)
                apply_stimulus($urandom_range(0, 3) != 0, rnd_sample(), rnd_sample(),
                               $urandom_range(0, 15) == 0, 0, 8'd0, 32'd0);
        end
        flush(6);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
